// File: rtl/input_debouncer.sv
// input_debouncer: counts consecutive samples that disagree with the current debounced level
// and accepts the new level only after DEBOUNCE_CYCLES of them in a row.
// Build option: define INPUT_DEBOUNCER_SYNC_EN to insert a 2-flop synchronizer on din
// (adds 2 cycles of latency); leave it undefined when din is already synchronous to clk.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic change,
  output logic stable
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_d;
  logic             change_d;
  logic             s;

`ifdef INPUT_DEBOUNCER_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer: din may be asynchronous to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = din;
`endif

  // Next-state: a disagreeing sample advances the count; an agreeing one (glitch) clears it.
  always_comb begin
    state_d  = StIdle;
    cnt_d    = '0;
    q_d      = q;
    change_d = 1'b0;
    if (s != q) begin
      if (cnt_q == CntLast) begin
        q_d      = s;
        change_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StCount;
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q       <= 1'b0;
      change  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q       <= q_d;
      change  <= change_d;
    end
  end

  assign stable = (state_q == StIdle);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (DEBOUNCE_CYCLES=4). Expected latencies adapt to whether
// INPUT_DEBOUNCER_SYNC_EN is defined.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif
  localparam int Lat = SyncLat + 4;

  logic clk;
  logic reset;
  logic din;
  logic q;
  logic change;
  logic stable;

  int n_checks;
  int n_fail;

  input_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .q     (q),
    .change(change),
    .stable(stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic eq, input logic ec, input logic es);
    check_eq({tag, ".q"}, q, eq);
    check_eq({tag, ".change"}, change, ec);
    check_eq({tag, ".stable"}, stable, es);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    din      = 1'b0;
    reset    = 1'b0;
    #12;
    check_all("in_reset", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;

    // Idle with din=0.
    for (int i = 0; i < 10; i++) begin
      step();
      check_all("idle0", 1'b0, 1'b0, 1'b1);
    end

    // Glitch: din high for 3 sampling edges then low -> no update.
    din = 1'b1;
    for (int i = 0; i < 3; i++) step();
    din = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("glitch.q", q, 1'b0);
      check_eq("glitch.change", change, 1'b0);
    end
    check_eq("glitch.stable_end", stable, 1'b1);

    // Rising edge held: q rises exactly Lat edges later with a one-cycle change pulse.
    din = 1'b1;
    for (int k = 1; k <= Lat; k++) begin
      step();
      check_all("rise", (k >= Lat), (k == Lat), !((k > SyncLat) && (k < Lat)));
    end
    step();
    check_all("rise_after", 1'b1, 1'b0, 1'b1);

    // Toggling every cycle never accumulates a full count.
    for (int i = 0; i < 20; i++) begin
      din = ~din;
      step();
      check_eq("toggle.q", q, 1'b1);
      check_eq("toggle.change", change, 1'b0);
    end
    din = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_all("settle1", 1'b1, 1'b0, 1'b1);

    // Falling edge held.
    din = 1'b0;
    for (int k = 1; k <= Lat; k++) begin
      step();
      check_all("fall", (k < Lat), (k == Lat), !((k > SyncLat) && (k < Lat)));
    end
    step();
    check_all("fall_after", 1'b0, 1'b0, 1'b1);

    // Reset mid-count: counting restarts from zero after release.
    din = 1'b1;
    for (int i = 0; i < SyncLat + 2; i++) step();
    check_eq("midcount.stable", stable, 1'b0);
    check_eq("midcount.q", q, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("rst_async", 1'b0, 1'b0, 1'b1);
    #3;
    reset = 1'b1;
    for (int k = 1; k <= Lat; k++) begin
      step();
      check_eq("post_rst.q", q, (k >= Lat));
      check_eq("post_rst.change", change, (k == Lat));
    end
    step();
    check_all("post_rst_after", 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving consecutive disagreeing samples needed to accept a new level; legal range 1..2^CNT_W.
REQ-002 SHALL have parameter CNT_W, default 3, giving the counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset==0 resets).
REQ-005 SHALL have port din, input, 1 bit: raw, bouncy, possibly asynchronous level from a switch or pin.
REQ-006 SHALL have port q, output reg, 1 bit: debounced level driving the downstream transition-detector FSM input.
REQ-007 SHALL have port change, output reg, 1 bit: one-cycle pulse on the cycle q takes a new value.
REQ-008 SHALL have port stable, output, 1 bit: high when the FSM is in IDLE.

Function
REQ-009 SHALL derive sample s from din per REQ-024/REQ-025.
REQ-010 SHALL implement a 2-state FSM: IDLE (s==q, cnt==0) and COUNT (s!=q, accumulating).
REQ-011 At each posedge, if s==q, SHALL set cnt<=0 and state<=IDLE; q is held.
REQ-012 At each posedge, if s!=q and cnt!=DEBOUNCE_CYCLES-1, SHALL set cnt<=cnt+1 and state<=COUNT.
REQ-013 At each posedge, if s!=q and cnt==DEBOUNCE_CYCLES-1, SHALL set q<=s, cnt<=0, change<=1, and state<=IDLE.
REQ-014 change SHALL be 0 on every posedge where REQ-013 does not apply, so it is never high for two consecutive cycles.
REQ-015 Latency from s first differing from q to q update SHALL be exactly DEBOUNCE_CYCLES posedges.
REQ-016 A glitch, where s returns to q before the count completes, SHALL clear cnt to 0 with no change pulse and no q update.
REQ-017 With DEBOUNCE_CYCLES==1, q SHALL follow s on the first posedge s differs, and state SHALL never remain in COUNT.
REQ-018 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 stable SHALL be 0 whenever a count is in progress.

Reset
REQ-020 While reset==0, SHALL asynchronously force q=0, change=0, cnt=0, state=IDLE (stable=1), and clear the synchronizer flops to 0.
REQ-021 Reset asserted mid-count SHALL abandon the count; after release, counting restarts from 0.
REQ-022 After reset release with din held at 1, q SHALL rise after the full latency of REQ-015 plus any synchronizer delay.

Configuration
REQ-023 SHALL honour the preprocessor macro INPUT_DEBOUNCER_SYNC_EN.
REQ-024 With INPUT_DEBOUNCER_SYNC_EN defined, SHALL take s from a 2-flop synchronizer on din, both flops reset to 0, adding exactly 2 posedges of latency.
REQ-025 Without INPUT_DEBOUNCER_SYNC_EN, SHALL use s = din directly, for callers whose din is already synchronous to clk.

Verification (DEBOUNCE_CYCLES=4, SYNC_EN defined unless noted)
REQ-026 Reset low then high, din=0 held 10 cycles -> q=0, change=0, stable=1 throughout.
REQ-027 din 0->1 held -> q rises on the 6th posedge after the first edge sampling din=1, change high for exactly that one cycle.
REQ-028 din=1 for 3 cycles, then 0 -> q stays 0, no change pulse, stable returns to 1.
REQ-029 q=1 settled, then din toggles every cycle for 20 cycles -> q stays 1, change stays 0.
REQ-030 Reset pulsed low during COUNT (cnt=2) -> q=0, cnt=0 immediately; with din still 1, q rises 6 posedges after release.
REQ-031 SYNC_EN undefined, din 0->1 held -> q rises on the 4th posedge sampling din=1.
